smm_operand_loader: RTL and testbench

Streaming operand front end for the Strassen matrix-multiply core: accepts 32 words over a valid/ready stream (16 words of A, then 16 of B, row-major), assembles them into the flat 4x4 operand buses the core consumes, and raises the core's `load` strobe. It replaces constant operands on the board wrapper with data delivered from a host link. Operand outputs are double-buffered, so the core always sees a complete, stable frame while the next one fills.

---
 rtl/smm_pkg.sv | 11 +
 rtl/smm_operand_loader.sv | 100 ++++++++++
 tb/tb_smm_operand_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/smm_pkg.sv
// smm_pkg: shared types and constants for the Strassen matrix-multiply front end, core and board wrappers.
package smm_pkg;
    localparam int DATAWIDTH = 32;
    localparam int ELEMS = 16;

    typedef enum logic [1:0] {FILL_A, FILL_B, LOAD, SYNC} smm_state_e;

    function automatic int elem_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/smm_operand_loader.sv
// smm_operand_loader: assembles a 32-word A/B stream into double-buffered 4x4 operand buses and strobes load.
module smm_operand_loader #(
    parameter int DATAWIDTH = smm_pkg::DATAWIDTH,
    parameter int ELEMS = smm_pkg::ELEMS,
    parameter int LOAD_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATAWIDTH-1:0]       s_data,
    input  logic                       s_last,
    output logic [DATAWIDTH*ELEMS-1:0] A,
    output logic [DATAWIDTH*ELEMS-1:0] B,
    output logic                       load,
    output logic                       err,
    output logic [7:0]                 frame_cnt
);
    import smm_pkg::*;

    localparam int W = DATAWIDTH * ELEMS;
    localparam int CW = $clog2(LOAD_HOLD + 1);

    smm_state_e     state_q;
    logic [3:0]     idx_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   stage_a_q, stage_b_q, a_q, b_q;
    logic           ready_q, load_q, err_q;
    logic [7:0]     frame_cnt_q;
    logic           xfer, last_idx;

    assign xfer = s_valid & ready_q;
    assign last_idx = idx_q == 4'(ELEMS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL_A;
            idx_q       <= '0;
            cnt_q       <= '0;
            stage_a_q   <= '0;
            stage_b_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ready_q     <= 1'b0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                FILL_A: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        stage_a_q[elem_lo(int'(idx_q), DATAWIDTH) +: DATAWIDTH] <= s_data;
                        idx_q   <= (s_last | last_idx) ? '0 : idx_q + 4'd1;
                        state_q <= (!s_last && last_idx) ? FILL_B : FILL_A;
                        err_q   <= err_q | s_last;
                    end
                end
                FILL_B: begin
                    if (xfer) begin
                        stage_b_q[elem_lo(int'(idx_q), DATAWIDTH) +: DATAWIDTH] <= s_data;
                        idx_q <= (s_last | last_idx) ? '0 : idx_q + 4'd1;
                        // Final B word bypasses staging so the commit lands on its own transfer edge.
                        if (last_idx && s_last) begin
                            a_q         <= stage_a_q;
                            b_q         <= {s_data, stage_b_q[W-DATAWIDTH-1:0]};
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            load_q      <= 1'b1;
                            ready_q     <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= LOAD;
                        end else begin
                            err_q   <= err_q | s_last | last_idx;
                            state_q <= s_last ? FILL_A : last_idx ? SYNC : FILL_B;
                        end
                    end
                end
                LOAD: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(LOAD_HOLD - 1)) begin
                        load_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= FILL_A;
                    end
                end
                SYNC: begin
                    if (xfer && s_last) state_q <= FILL_A;
                end
                default: state_q <= FILL_A;
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign A         = a_q;
    assign B         = b_q;
    assign load      = load_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_smm_operand_loader.sv
// tb_smm_operand_loader: randomized stream stimulus checked against a word-counting frame model.
module tb_smm_operand_loader;
    localparam int DW = 32;
    localparam int NE = 16;
    localparam int LH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     s_data = '0;
    logic              s_last = 1'b0;
    logic [DW*NE-1:0]  A, B;
    logic              load, err;
    logic [7:0]        frame_cnt;

    smm_operand_loader #(.DATAWIDTH(DW), .ELEMS(NE), .LOAD_HOLD(LH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .A(A), .B(B), .load(load), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: words since the last frame boundary; a frame is exactly 32 words ending in s_last.
    logic [DW-1:0]    mbuf [32];
    int               mcnt;
    bit               msync;
    logic [DW*NE-1:0] exp_a, exp_b;
    logic [7:0]       exp_fc;
    bit               exp_err;
    logic [DW-1:0]    q_d [$];
    bit               q_l [$];
    bit               skip_load_check = 0;

    task automatic model_reset();
        mcnt = 0; msync = 0; exp_a = '0; exp_b = '0; exp_fc = '0; exp_err = 0;
    endtask

    function automatic bit model_push(input logic [DW-1:0] d, input bit l);
        if (msync) begin
            if (l) msync = 0;
            return 0;
        end
        mbuf[mcnt] = d;
        mcnt++;
        if (l) begin
            if (mcnt == 32) begin
                for (int k = 0; k < NE; k++) begin
                    exp_a[k*DW +: DW] = mbuf[k];
                    exp_b[k*DW +: DW] = mbuf[NE + k];
                end
                exp_fc = 8'((int'(exp_fc) + 1) % 256);
                mcnt = 0;
                return 1;
            end
            exp_err = 1;
            mcnt = 0;
            return 0;
        end
        if (mcnt == 32) begin
            exp_err = 1;
            msync = 1;
            mcnt = 0;
        end
        return 0;
    endfunction

    task automatic queue_frame(input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            q_d.push_back($urandom);
            q_l.push_back(i == last_pos);
        end
    endtask

    task automatic check_load_pulse();
        int n = 0;
        while (load === 1'b1 && n < LH + 4) begin
            checks++;
            if (s_ready !== 1'b0) $display("FAIL ready_in_load: s_ready=%b required 0", s_ready);
            else passed++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== LH) $display("FAIL load_width: load high %0d cycles, required %0d", n, LH);
        else passed++;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL ready_after_load: s_ready=%b required 1", s_ready);
        else passed++;
    endtask

    // gap: 0 = s_valid continuous, 1 = idle cycle between words, 2 = random idle cycles
    task automatic run_queue(input int gap);
        logic [DW-1:0] d;
        bit l, com;
        int n;
        while (q_d.size() > 0) begin
            d = q_d.pop_front();
            l = q_l.pop_front();
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom);
                @(posedge clk); #1;
            end
            s_valid = 1'b1; s_data = d; s_last = l;
            n = 0;
            while (!s_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!s_ready) begin
                checks++;
                $display("FAIL ready_timeout: s_ready=%b required 1 within 50 cycles", s_ready);
                q_d.delete(); q_l.delete();
                break;
            end
            @(posedge clk); #1;
            s_valid = 1'b0;
            com = model_push(d, l);
            checks++;
            if (A !== exp_a || B !== exp_b) $display("FAIL operands: A=%h B=%h required A=%h B=%h", A, B, exp_a, exp_b);
            else passed++;
            checks++;
            if (frame_cnt !== exp_fc || err !== exp_err)
                $display("FAIL status: frame_cnt=%0d err=%b required frame_cnt=%0d err=%b", frame_cnt, err, exp_fc, exp_err);
            else passed++;
            checks++;
            if (load !== com || s_ready !== !com) $display("FAIL load_start: load=%b s_ready=%b required load=%b s_ready=%b", load, s_ready, com, !com);
            else passed++;
            if (com && !skip_load_check) check_load_pulse();
        end
        s_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (A !== '0 || B !== '0 || load !== 1'b0 || err !== 1'b0 || frame_cnt !== 8'd0 || s_ready !== 1'b0)
            $display("FAIL %s: A=%h B=%h load=%b err=%b frame_cnt=%0d s_ready=%b required all 0", name, A, B, load, err, frame_cnt, s_ready);
        else passed++;
    endtask

    task automatic release_reset(input string name);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL %s: s_ready=%b required 1 after release", name, s_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        release_reset("reset_release");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 32; i++) begin
            q_d.push_back(i < 16 ? DW'(i + 1) : DW'(32'h16 - (i - 16)));
            q_l.push_back(i == 31);
        end
        run_queue(0);
        checks++;
        if (A[31:0] !== 32'd1 || B[31:0] !== 32'h16) $display("FAIL basic_words: A0=%h B0=%h required A0=1 B0=16", A[31:0], B[31:0]);
        else passed++;
    endtask

    task automatic test_toggle_valid();
        queue_frame(32, 31);
        run_queue(1);
        queue_frame(32, 31);
        run_queue(2);
    endtask

    task automatic test_early_last();
        queue_frame(10, 9);
        run_queue(0);
        queue_frame(32, 31);
        run_queue(2);
    endtask

    task automatic test_missing_last();
        queue_frame(32, -1);
        queue_frame(3, 2);
        queue_frame(32, 31);
        run_queue(0);
    endtask

    task automatic test_reset_mid();
        queue_frame(20, -1);
        run_queue(0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1 check_all_zero("reset_mid_frame");
        release_reset("reset_mid_frame_release");
        queue_frame(32, 31);
        skip_load_check = 1;
        run_queue(0);
        skip_load_check = 0;
        @(posedge clk); #1;
        checks++;
        if (load !== 1'b1) $display("FAIL load_second_cycle: load=%b required 1", load);
        else passed++;
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid_load");
        release_reset("reset_mid_load_release");
        queue_frame(32, 31);
        run_queue(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] start;
        start = frame_cnt;
        for (int f = 0; f < 256; f++) queue_frame(32, 31);
        run_queue(0);
        checks++;
        if (frame_cnt !== start) $display("FAIL frame_cnt_wrap: frame_cnt=%0d required %0d", frame_cnt, start);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
